half_stream_transpose: RTL and testbench
========================================

# half_stream_transpose

Streaming, double-buffered matrix transposer for IEEE-754 half-precision (or any DATA_W) elements. It accepts a WIDTH x HEIGHT matrix one element per cycle in row-major order (outer index i over WIDTH, inner index j over HEIGHT). It emits the HEIGHT x WIDTH transpose in row-major order, or the original matrix unchanged in pass-through mode, also one element per cycle. It sits between serial producers (DMA, layer outputs) and matrix-multiply or activation stages, and replaces wide all-parallel array ports with valid/ready streams.

## Interface
- WIDTH, 10, outer dimension of the input matrix (≥1)
- HEIGHT, 10, inner dimension of the input matrix (≥1)
- DATA_W, 16, element width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  element offered
- in_ready  output  1  element accepted when in_valid && in_ready
- in_data  input  DATA_W  element m_in[i][j]
- in_last  input  1  producer's marker for the final element of a matrix
- mode_tr  input  1  1 = transpose, 0 = pass-through; sampled with each matrix's first element
- out_valid  output  1  out_data holds an element
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_data  output  DATA_W  output element
- out_row_last  output  1  final element of an output row
- out_last  output  1  final element of the matrix
- err_last  output  1  sticky; in_last disagrees with the element count

## Operation
- Two banks, each N = WIDTH*HEIGHT entries. Each bank has state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side: wbank toggles after each complete matrix. The write address increments linearly 0..N-1, which gives addr = i*HEIGHT + j. mode_tr is latched per bank on the first element.
- in_ready = 1 when bank[wbank] is EMPTY or FILLING.
- Matrix boundary is set by the element count only; in_last is advisory. err_last sets if in_last=1 on any element other than the N-th, or in_last=0 on the N-th. err_last clears only on reset.
- Read side: rbank toggles after each drained matrix.
- Transpose read order: for j in 0..HEIGHT-1, for i in 0..WIDTH-1, addr = i*HEIGHT + j. This is produced by adding HEIGHT each step and wrapping to j+1 after WIDTH steps, with no multiplier. Output rows have length WIDTH.
- Pass-through read order: linear 0..N-1. Output rows have length HEIGHT.
- out_row_last is high on the last element of each output row. out_last is high on element N-1 only, and coincides with out_row_last.
- Output register loads whenever !out_valid || out_ready. Holding out_ready low must not drop, duplicate or reorder elements.
- A bank goes EMPTY when its last element is loaded into the output register. That bank may be refilled from the next cycle.
- Write and read of different banks in the same cycle are independent. A bank is never read and written simultaneously.
- WIDTH=1 or HEIGHT=1 is legal. Transpose then equals pass-through order with different row markers.

## Timing
- Reset values (asynchronous): in_ready=1 after release; out_valid=0; out_data=0; out_row_last=0; out_last=0; err_last=0; both banks EMPTY; wbank=rbank=0; all counters 0.
- Reset mid-operation discards all buffered data and partial matrices immediately. Memory contents need no reset.
- Latency: if the last element of a matrix is accepted in cycle T, out_valid for its first element asserts in cycle T+2.
- Throughput: with out_ready held at 1, continuous input is accepted at 1 element per cycle indefinitely. Output is 1 element per cycle with no bubble between matrices.
- Backpressure: with out_ready=0, in_ready falls after exactly 2N elements have been accepted. in_ready rises again in the cycle after the first bank empties.

## Structure
- The shared package half_pkg holds the DATA_W default (16), the bank_state_t enum (EMPTY, FILLING, FULL, DRAINING), and an address-width function based on $clog2(WIDTH*HEIGHT).
- Sub-module half_tbuf_bank contains one bank: storage array, synchronous write, asynchronous read, and the state register. The top level instantiates it twice and owns the write/read counters, transpose address generator, output register and error flag.

## Test plan
- WIDTH=2, HEIGHT=3, mode_tr=1, inputs 0..5, out_ready=1 -> outputs 0,3,1,4,2,5. out_row_last on 3, 4 and 5; out_last on 5 only; first out_valid 2 cycles after in_data=5 is accepted.
- Same dimensions, mode_tr=0 -> outputs 0..5 in order. out_row_last on 2 and 5.
- Back-to-back matrices with alternating modes, 0..5 then 6..11 -> output 0,3,1,4,2,5,6..11. in_ready stays 1 and there is no output gap.
- out_ready=0 throughout -> exactly 12 elements accepted, then in_ready=0. Raising out_ready -> 0,3,1,4,2,5 in order, and in_ready returns.
- in_last=1 on element 3 of 6 -> err_last=1 from the next cycle and stays set. Data ordering is unaffected.
- Assert rst_n low after 4 of 6 elements -> outputs and states return to reset values immediately. A following full matrix transposes correctly.

Source files
------------

// File: rtl/half_pkg.sv
// Shared definitions for the half-precision stream transposer.
//   DATA_W_DEFAULT : default element width (IEEE-754 half)
//   bank_state_t   : life cycle of one buffer bank
//   addr_width()   : address bits needed for an n-entry bank (at least 1)
package half_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // A one-entry bank still needs a one-bit address so index widths stay legal.
    function automatic int addr_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/half_stream_transpose_if.sv
// Stream bundle of the transposer: input element stream, output element
// stream and the sticky in_last error flag.
//   slave  : transposer side (consumes in_*, produces out_* and err_last)
//   master : environment side (producer and consumer)
interface half_stream_transpose_if #(
    parameter int DATA_W = half_pkg::DATA_W_DEFAULT
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mode_tr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_row_last;
    logic              out_last;
    logic              err_last;

    modport slave (
        input  in_valid, in_data, in_last, mode_tr, out_ready,
        output in_ready, out_valid, out_data, out_row_last, out_last, err_last
    );

    modport master (
        output in_valid, in_data, in_last, mode_tr, out_ready,
        input  in_ready, out_valid, out_data, out_row_last, out_last, err_last
    );
endinterface

// File: rtl/half_tbuf_bank.sv
// One buffer bank of the transposer: DEPTH-entry storage with synchronous
// write and asynchronous read, the bank state register and the mode bit
// captured with the first element written into an empty bank.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_last       write strobe / this write is the final element
//   wr_mode             mode_tr presented with the write
//   wr_addr/wr_data     write address and element
//   rd_en/rd_last       element taken by the output register / final one
//   rd_addr/rd_data     asynchronous read port
//   state, mode         current bank state and latched mode
module half_tbuf_bank
    import half_pkg::*;
#(
    parameter int DEPTH  = 100,
    parameter int AW     = 7,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_last,
    input  logic              wr_mode,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_last,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output bank_state_t       state,
    output logic              mode
);

    bank_state_t       state_r;
    bank_state_t       state_nxt_s;
    logic              mode_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Bank life cycle; a one-entry bank jumps straight to FULL / EMPTY.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (wr_en) begin
                    state_nxt_s = wr_last ? FULL : FILLING;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FILLING: begin
                if (wr_en && wr_last) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = FILLING;
                end
            end
            FULL: begin
                if (rd_en) begin
                    state_nxt_s = rd_last ? EMPTY : DRAINING;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            DRAINING: begin
                if (rd_en && rd_last) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = DRAINING;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mode is fixed for the whole matrix by its first element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= 1'b0;
        end else if (wr_en && (state_r == EMPTY)) begin
            mode_r <= wr_mode;
        end
    end

    // Element storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];
    assign state   = state_r;
    assign mode    = mode_r;

endmodule

// File: rtl/half_stream_transpose.sv
// Streaming double-buffered WIDTH x HEIGHT transposer. Elements arrive in
// row-major order (outer i over WIDTH, inner j over HEIGHT) and leave either
// as the HEIGHT x WIDTH transpose or unchanged (mode_tr latched per matrix).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         half_stream_transpose_if.slave: in_valid/in_ready/in_data/
//               in_last/mode_tr, out_valid/out_ready/out_data/out_row_last/
//               out_last, sticky err_last
module half_stream_transpose
    import half_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    half_stream_transpose_if.slave   bus
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = addr_width(N);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW-1:0] W_LAST   = AW'(WIDTH - 1);
    localparam logic [AW-1:0] H_LAST   = AW'(HEIGHT - 1);
    localparam logic [AW-1:0] H_STEP   = AW'(HEIGHT);

    // Bank-side signals
    bank_state_t       state_s   [2];
    logic              mode_s    [2];
    logic [DATA_W-1:0] rd_data_s [2];
    logic              wr_en_s   [2];
    logic              rd_en_s   [2];

    // Write side
    logic              wbank_r;
    logic [AW-1:0]     wcnt_r;
    logic              err_last_r;
    logic              in_ready_s;
    logic              wr_fire_s;
    logic              wr_last_s;

    // Read side
    logic              rbank_r;
    logic [AW-1:0]     rd_cnt_r;
    logic [AW-1:0]     rd_addr_r;
    logic [AW-1:0]     rd_pos_r;   // position inside the current output row
    logic [AW-1:0]     rd_col_r;   // j of the current transposed row
    logic [AW-1:0]     rd_addr_nxt_s;
    logic [AW-1:0]     rd_pos_nxt_s;
    logic [AW-1:0]     rd_col_nxt_s;
    logic              rd_avail_s;
    logic              load_s;
    logic              rd_fire_s;
    logic              rd_mode_s;
    logic              rd_last_s;
    logic              rd_row_last_s;

    // Output register
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_row_last_r;
    logic              out_last_r;

    // Handshake decode and per-bank strobes.
    always_comb begin
        in_ready_s    = (state_s[wbank_r] == EMPTY) || (state_s[wbank_r] == FILLING);
        wr_fire_s     = bus.in_valid && in_ready_s;
        wr_last_s     = (wcnt_r == LAST_IDX);
        rd_avail_s    = (state_s[rbank_r] == FULL) || (state_s[rbank_r] == DRAINING);
        load_s        = !out_valid_r || bus.out_ready;
        rd_fire_s     = rd_avail_s && load_s;
        rd_mode_s     = mode_s[rbank_r];
        rd_last_s     = (rd_cnt_r == LAST_IDX);
        rd_row_last_s = rd_mode_s ? (rd_pos_r == W_LAST) : (rd_pos_r == H_LAST);
        wr_en_s[0]    = wr_fire_s && (wbank_r == 1'b0);
        wr_en_s[1]    = wr_fire_s && (wbank_r == 1'b1);
        rd_en_s[0]    = rd_fire_s && (rbank_r == 1'b0);
        rd_en_s[1]    = rd_fire_s && (rbank_r == 1'b1);
    end

    // Read address generator: transpose steps by HEIGHT and restarts at j+1
    // after each output row, so no multiplier is needed.
    always_comb begin
        rd_addr_nxt_s = rd_addr_r;
        rd_pos_nxt_s  = rd_pos_r;
        rd_col_nxt_s  = rd_col_r;
        if (rd_last_s) begin
            rd_addr_nxt_s = '0;
            rd_pos_nxt_s  = '0;
            rd_col_nxt_s  = '0;
        end else if (rd_mode_s) begin
            if (rd_row_last_s) begin
                rd_col_nxt_s  = rd_col_r + AW'(1);
                rd_addr_nxt_s = rd_col_r + AW'(1);
                rd_pos_nxt_s  = '0;
            end else begin
                rd_addr_nxt_s = rd_addr_r + H_STEP;
                rd_pos_nxt_s  = rd_pos_r + AW'(1);
            end
        end else begin
            rd_addr_nxt_s = rd_addr_r + AW'(1);
            if (rd_row_last_s) begin
                rd_pos_nxt_s = '0;
            end else begin
                rd_pos_nxt_s = rd_pos_r + AW'(1);
            end
        end
    end

    // Write counter, write bank select and sticky in_last check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_r    <= 1'b0;
            wcnt_r     <= '0;
            err_last_r <= 1'b0;
        end else if (wr_fire_s) begin
            if (wr_last_s) begin
                wcnt_r  <= '0;
                wbank_r <= ~wbank_r;
            end else begin
                wcnt_r  <= wcnt_r + AW'(1);
            end
            if (bus.in_last != wr_last_s) begin
                err_last_r <= 1'b1;
            end
        end
    end

    // Read counters, read bank select and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank_r        <= 1'b0;
            rd_cnt_r       <= '0;
            rd_addr_r      <= '0;
            rd_pos_r       <= '0;
            rd_col_r       <= '0;
            out_valid_r    <= 1'b0;
            out_data_r     <= '0;
            out_row_last_r <= 1'b0;
            out_last_r     <= 1'b0;
        end else if (rd_fire_s) begin
            rd_addr_r      <= rd_addr_nxt_s;
            rd_pos_r       <= rd_pos_nxt_s;
            rd_col_r       <= rd_col_nxt_s;
            if (rd_last_s) begin
                rd_cnt_r <= '0;
                rbank_r  <= ~rbank_r;
            end else begin
                rd_cnt_r <= rd_cnt_r + AW'(1);
            end
            out_valid_r    <= 1'b1;
            out_data_r     <= rd_data_s[rbank_r];
            out_row_last_r <= rd_row_last_s;
            out_last_r     <= rd_last_s;
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end
    end

    half_tbuf_bank #(
        .DEPTH  (N),
        .AW     (AW),
        .DATA_W (DATA_W)
    ) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s[0]),
        .wr_last (wr_last_s),
        .wr_mode (bus.mode_tr),
        .wr_addr (wcnt_r),
        .wr_data (bus.in_data),
        .rd_en   (rd_en_s[0]),
        .rd_last (rd_last_s),
        .rd_addr (rd_addr_r),
        .rd_data (rd_data_s[0]),
        .state   (state_s[0]),
        .mode    (mode_s[0])
    );

    half_tbuf_bank #(
        .DEPTH  (N),
        .AW     (AW),
        .DATA_W (DATA_W)
    ) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s[1]),
        .wr_last (wr_last_s),
        .wr_mode (bus.mode_tr),
        .wr_addr (wcnt_r),
        .wr_data (bus.in_data),
        .rd_en   (rd_en_s[1]),
        .rd_last (rd_last_s),
        .rd_addr (rd_addr_r),
        .rd_data (rd_data_s[1]),
        .state   (state_s[1]),
        .mode    (mode_s[1])
    );

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign bus.out_row_last = out_row_last_r;
    assign bus.out_last     = out_last_r;
    assign bus.err_last     = err_last_r;

endmodule

// File: tb/tb_half_stream_transpose.sv
// Directed bench for half_stream_transpose with a 2x3 matrix.
module tb_half_stream_transpose;

    localparam int W  = 2;
    localparam int H  = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp observed events.
    always @(posedge clk) cyc <= cyc + 1;

    half_stream_transpose_if #(.DATA_W(DW)) bus ();

    half_stream_transpose #(
        .WIDTH  (W),
        .HEIGHT (H),
        .DATA_W (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Observed transactions, recorded on the falling edge.
    logic [DW-1:0] out_q    [$];
    logic          out_rl_q [$];
    logic          out_l_q  [$];
    int            out_c_q  [$];
    int            acc_c_q  [$];
    bit            err_seen = 1'b0;
    int            err_cyc  = 0;

    // Monitor for accepted inputs, delivered outputs and first err_last.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(bus.out_data);
                out_rl_q.push_back(bus.out_row_last);
                out_l_q.push_back(bus.out_last);
                out_c_q.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) acc_c_q.push_back(cyc);
            if (bus.err_last && !err_seen) begin
                err_seen = 1'b1;
                err_cyc  = cyc;
            end
        end
    end

    // Offer n elements base..base+n-1; mode_tr is correct only on the first
    // element so per-matrix latching is exercised. Starts/ends at posedge+1.
    task automatic send(input int base, input bit mode, input int n,
                        input int last_idx, output int stalls);
        int t;
        bit rdy;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(base + k);
            bus.in_last  = (k == last_idx);
            bus.mode_tr  = (k == 0) ? mode : !mode;
            t = 0;
            rdy = bus.in_ready;
            @(posedge clk); #1;
            while (!rdy && t < 50) begin
                stalls++;
                t++;
                rdy = bus.in_ready;
                @(posedge clk); #1;
            end
            if (!rdy) begin
                n_checks++;
                $display("FAIL send_timeout element %0d: in_ready stayed 0, required 1", base + k);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_outputs(input int target, input string name);
        int t = 0;
        while (out_q.size() < target && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (out_q.size() >= target) n_pass++;
        else $display("FAIL %s_wait: got %0d outputs, required %0d", name, out_q.size(), target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 16'h0000) $display("FAIL reset_out_data: got %h, required 0000", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_row_last !== 1'b0) $display("FAIL reset_out_row_last: got %b, required 0", bus.out_row_last); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last: got %b, required 0", bus.out_last); else n_pass++;
        n_checks++; if (bus.err_last !== 1'b0) $display("FAIL reset_err_last: got %b, required 0", bus.err_last); else n_pass++;
    endtask

    task automatic test_transpose();
        int b, a, s;
        int exp_v [6] = '{0, 3, 1, 4, 2, 5};
        logic [5:0] rl, lst;
        b = out_q.size();
        a = acc_c_q.size();
        bus.out_ready = 1'b1;
        send(0, 1'b1, 6, 5, s);
        wait_outputs(b + 6, "transpose");
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (out_q[b+k] !== 16'(exp_v[k])) $display("FAIL transpose_data[%0d]: got %0d, required %0d", k, out_q[b+k], exp_v[k]);
            else n_pass++;
            rl[k]  = out_rl_q[b+k];
            lst[k] = out_l_q[b+k];
        end
        n_checks++; if (rl !== 6'b101010) $display("FAIL transpose_row_last: got %b, required 101010", rl); else n_pass++;
        n_checks++; if (lst !== 6'b100000) $display("FAIL transpose_last: got %b, required 100000", lst); else n_pass++;
        n_checks++;
        if (out_c_q[b] - acc_c_q[a+5] !== 2) $display("FAIL transpose_latency: got %0d cycles, required 2", out_c_q[b] - acc_c_q[a+5]);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        int b, s;
        logic [5:0] rl, lst;
        b = out_q.size();
        bus.out_ready = 1'b1;
        send(0, 1'b0, 6, 5, s);
        wait_outputs(b + 6, "passthrough");
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (out_q[b+k] !== 16'(k)) $display("FAIL passthrough_data[%0d]: got %0d, required %0d", k, out_q[b+k], k);
            else n_pass++;
            rl[k]  = out_rl_q[b+k];
            lst[k] = out_l_q[b+k];
        end
        n_checks++; if (rl !== 6'b100100) $display("FAIL passthrough_row_last: got %b, required 100100", rl); else n_pass++;
        n_checks++; if (lst !== 6'b100000) $display("FAIL passthrough_last: got %b, required 100000", lst); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int b, s1, s2, gaps;
        int exp_v [12] = '{0, 3, 1, 4, 2, 5, 6, 7, 8, 9, 10, 11};
        logic [11:0] rl, lst;
        b = out_q.size();
        bus.out_ready = 1'b1;
        send(0, 1'b1, 6, 5, s1);
        send(6, 1'b0, 6, 5, s2);
        wait_outputs(b + 12, "b2b");
        n_checks++; if (s1 + s2 !== 0) $display("FAIL b2b_in_ready: got %0d stall cycles, required 0", s1 + s2); else n_pass++;
        gaps = 0;
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (out_q[b+k] !== 16'(exp_v[k])) $display("FAIL b2b_data[%0d]: got %0d, required %0d", k, out_q[b+k], exp_v[k]);
            else n_pass++;
            rl[k]  = out_rl_q[b+k];
            lst[k] = out_l_q[b+k];
            if (k > 0 && out_c_q[b+k] - out_c_q[b+k-1] != 1) gaps++;
        end
        n_checks++; if (gaps !== 0) $display("FAIL b2b_gap: got %0d gaps, required 0", gaps); else n_pass++;
        n_checks++; if (rl !== 12'b1001_0010_1010) $display("FAIL b2b_row_last: got %b, required 100100101010", rl); else n_pass++;
        n_checks++; if (lst !== 12'b1000_0010_0000) $display("FAIL b2b_last: got %b, required 100000100000", lst); else n_pass++;
    endtask

    task automatic test_backpressure();
        int b, s1, s2, a0, k;
        int exp_v [12] = '{0, 3, 1, 4, 2, 5, 6, 9, 7, 10, 8, 11};
        b = out_q.size();
        bus.out_ready = 1'b0;
        send(0, 1'b1, 6, 5, s1);
        send(6, 1'b1, 6, 5, s2);
        n_checks++; if (s1 + s2 !== 0) $display("FAIL bp_accept12: got %0d stall cycles, required 0", s1 + s2); else n_pass++;
        a0 = acc_c_q.size();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd100;
        bus.mode_tr  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (acc_c_q.size() !== a0) $display("FAIL bp_extra_accept: got %0d, required 0", acc_c_q.size() - a0); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b, required 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd0) $display("FAIL bp_hold: got valid %b data %0d, required valid 1 data 0", bus.out_valid, bus.out_data); else n_pass++;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++; if (k !== 5) $display("FAIL bp_in_ready_return: got %0d cycles, required 5", k); else n_pass++;
        wait_outputs(b + 12, "bp");
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (out_q[b+i] !== 16'(exp_v[i])) $display("FAIL bp_data[%0d]: got %0d, required %0d", i, out_q[b+i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_err_last();
        int b, a, s;
        int exp_v [6] = '{30, 33, 31, 34, 32, 35};
        b = out_q.size();
        a = acc_c_q.size();
        n_checks++; if (bus.err_last !== 1'b0) $display("FAIL err_before: got %b, required 0", bus.err_last); else n_pass++;
        bus.out_ready = 1'b1;
        send(30, 1'b1, 6, 3, s);
        wait_outputs(b + 6, "err");
        n_checks++;
        if (!err_seen || err_cyc !== acc_c_q[a+3] + 1)
            $display("FAIL err_timing: got seen %b cycle %0d, required cycle %0d", err_seen, err_cyc, acc_c_q[a+3] + 1);
        else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (bus.err_last !== 1'b1) $display("FAIL err_sticky: got %b, required 1", bus.err_last); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (out_q[b+k] !== 16'(exp_v[k])) $display("FAIL err_data[%0d]: got %0d, required %0d", k, out_q[b+k], exp_v[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int b, s;
        int exp_v [6] = '{20, 23, 21, 24, 22, 25};
        bus.out_ready = 1'b0;
        send(40, 1'b1, 6, 5, s);
        send(50, 1'b1, 4, -1, s);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 16'h0000) $display("FAIL rmid_out_data: got %h, required 0000", bus.out_data); else n_pass++;
        n_checks++; if (bus.err_last !== 1'b0) $display("FAIL rmid_err_last: got %b, required 0", bus.err_last); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b, required 1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        b = out_q.size();
        send(20, 1'b1, 6, 5, s);
        wait_outputs(b + 6, "rmid");
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (out_q[b+k] !== 16'(exp_v[k])) $display("FAIL rmid_data[%0d]: got %0d, required %0d", k, out_q[b+k], exp_v[k]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_last   = 1'b0;
        bus.mode_tr   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_transpose();
        test_passthrough();
        test_back_to_back();
        test_backpressure();
        test_err_last();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
